// File: rtl/sisc_pkg.sv
// Opcodes, FSM state codes and alu_op codes shared by the SISC control sequencer.
package sisc_pkg;

  typedef enum logic [3:0] {
    OP_NOOP = 4'd0,
    OP_LOD  = 4'd1,
    OP_STR  = 4'd2,
    OP_SWP  = 4'd3,
    OP_BRA  = 4'd4,
    OP_BRR  = 4'd5,
    OP_BNE  = 4'd6,
    OP_BNR  = 4'd7,
    OP_ALU  = 4'd8,
    OP_HLT  = 4'd15
  } opcode_e;

  localparam int unsigned AM_IMM = 8;

  typedef enum logic [3:0] {
    S_START0  = 4'd0,
    S_START1  = 4'd1,
    S_FETCH   = 4'd2,
    S_DECODE  = 4'd3,
    S_EXECUTE = 4'd4,
    S_MEM     = 4'd5,
    S_WB      = 4'd6,
    S_WB2     = 4'd7,
    S_HALT    = 4'd8
  } state_e;

  typedef enum logic [1:0] {
    ALU_RR   = 2'b00,
    ALU_IMM  = 2'b01,
    ALU_PASS = 2'b10
  } aluop_e;

  function automatic logic is_mem_op(opcode_e op);
    return (op == OP_LOD) || (op == OP_STR);
  endfunction

endpackage

// File: rtl/sisc_ctrl_seq_if.sv
// IR/status inputs and datapath strobes of the sequencer; master = sequencer side.
// Perf counter signals exist only when SISC_CTRL_PERF_EN is defined.
interface sisc_ctrl_seq_if #(
  parameter int OP_W    = 4,
  parameter int MM_W    = 4,
  parameter int STAT_W  = 4,
  parameter int ALUOP_W = 2
);
  logic [OP_W-1:0]    opcode;
  logic [MM_W-1:0]    mm;
  logic [STAT_W-1:0]  stat;
  logic               mem_ready;
  logic               ir_load;
  logic               pc_write;
  logic               pc_sel;
  logic               br_sel;
  logic               pc_rst;
  logic               rf_we;
  logic               wb_sel;
  logic               rb_sel;
  logic [ALUOP_W-1:0] alu_op;
  logic               dm_re;
  logic               dm_we;
  logic               halted;
  logic [3:0]         state_dbg;
`ifdef SISC_CTRL_PERF_EN
  logic [31:0]        cyc_cnt;
  logic [31:0]        instr_cnt;
`endif

  modport master (
    input  opcode, mm, stat, mem_ready,
    output ir_load, pc_write, pc_sel, br_sel, pc_rst, rf_we, wb_sel, rb_sel,
    output alu_op, dm_re, dm_we, halted, state_dbg
`ifdef SISC_CTRL_PERF_EN
    , output cyc_cnt, instr_cnt
`endif
  );

  modport slave (
    output opcode, mm, stat, mem_ready,
    input  ir_load, pc_write, pc_sel, br_sel, pc_rst, rf_we, wb_sel, rb_sel,
    input  alu_op, dm_re, dm_we, halted, state_dbg
`ifdef SISC_CTRL_PERF_EN
    , input cyc_cnt, instr_cnt
`endif
  );

endinterface

// File: rtl/sisc_br_eval.sv
// Combinational branch evaluator: classifies the opcode and resolves taken/absolute.
module sisc_br_eval
  import sisc_pkg::*;
#(
  parameter int OP_W   = 4,
  parameter int MM_W   = 4,
  parameter int STAT_W = 4
) (
  input  logic [OP_W-1:0]   i_opcode,
  input  logic [MM_W-1:0]   i_mm,
  input  logic [STAT_W-1:0] i_stat,
  output logic              o_is_branch,
  output logic              o_taken,
  output logic              o_absolute
);

  opcode_e w_op;
  logic    w_hit;

  assign w_op  = opcode_e'(i_opcode);
  // mm acts as a mask over the flags; mm=0 can never hit
  assign w_hit = |(i_stat & i_mm);

  always_comb begin
    o_is_branch = 1'b0;
    o_taken     = 1'b0;
    o_absolute  = 1'b0;
    case (w_op)
      OP_BRA: begin o_is_branch = 1'b1; o_taken = w_hit;  o_absolute = 1'b1; end
      OP_BRR: begin o_is_branch = 1'b1; o_taken = w_hit;  o_absolute = 1'b0; end
      OP_BNE: begin o_is_branch = 1'b1; o_taken = !w_hit; o_absolute = 1'b1; end
      OP_BNR: begin o_is_branch = 1'b1; o_taken = !w_hit; o_absolute = 1'b0; end
      default: ;
    endcase
  end

endmodule

// File: rtl/sisc_ctrl_seq.sv
// SISC multi-cycle control sequencer: Moore-plus-opcode FSM driving datapath strobes.
// Optional perf counters (cyc_cnt/instr_cnt) enabled by defining SISC_CTRL_PERF_EN.
module sisc_ctrl_seq
  import sisc_pkg::*;
#(
  parameter int OP_W    = 4,
  parameter int MM_W    = 4,
  parameter int STAT_W  = 4,
  parameter int ALUOP_W = 2
) (
  input  logic             clk,
  input  logic             rst_f,
  sisc_ctrl_seq_if.master  bus
);

  state_e  r_state;
  state_e  w_state_next;
  opcode_e w_op;
  logic    w_is_branch;
  logic    w_taken;
  logic    w_absolute;
  aluop_e  w_alu_ex;

  assign w_op = opcode_e'(bus.opcode);

  sisc_br_eval #(
    .OP_W   (OP_W),
    .MM_W   (MM_W),
    .STAT_W (STAT_W)
  ) u_br_eval (
    .i_opcode    (bus.opcode),
    .i_mm        (bus.mm),
    .i_stat      (bus.stat),
    .o_is_branch (w_is_branch),
    .o_taken     (w_taken),
    .o_absolute  (w_absolute)
  );

  // alu_op seen from EXECUTE through WB2; non-ALU opcodes keep the ALU idle
  always_comb begin
    w_alu_ex = ALU_PASS;
    if (w_op == OP_ALU)
      w_alu_ex = (bus.mm == MM_W'(AM_IMM)) ? ALU_IMM : ALU_RR;
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) r_state <= S_START1;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_START0:  w_state_next = S_START1;
      S_START1:  w_state_next = S_FETCH;
      S_FETCH:   w_state_next = S_DECODE;
      S_DECODE:  w_state_next = (w_op == OP_HLT) ? S_HALT : S_EXECUTE;
      S_EXECUTE: w_state_next = S_MEM;
      S_MEM:     if (!is_mem_op(w_op) || bus.mem_ready) w_state_next = S_WB;
      S_WB:      w_state_next = (w_op == OP_SWP) ? S_WB2 : S_FETCH;
      S_WB2:     w_state_next = S_FETCH;
      S_HALT:    w_state_next = S_HALT;
      default:   w_state_next = S_START0;
    endcase
  end

  always_comb begin
    bus.ir_load   = 1'b0;
    bus.pc_write  = 1'b0;
    bus.pc_sel    = 1'b0;
    bus.br_sel    = 1'b0;
    bus.pc_rst    = 1'b0;
    bus.rf_we     = 1'b0;
    bus.wb_sel    = 1'b0;
    bus.rb_sel    = 1'b0;
    bus.alu_op    = ALUOP_W'(ALU_PASS);
    bus.dm_re     = 1'b0;
    bus.dm_we     = 1'b0;
    bus.halted    = 1'b0;
    bus.state_dbg = r_state;
    case (r_state)
      S_START0, S_START1: bus.pc_rst = 1'b1;
      S_FETCH: begin
        bus.ir_load  = 1'b1;
        bus.pc_write = 1'b1;
      end
      S_DECODE: begin
        if (w_is_branch && w_taken) begin
          bus.pc_write = 1'b1;
          bus.pc_sel   = 1'b1;
          bus.br_sel   = w_absolute;
        end
      end
      S_EXECUTE: bus.alu_op = ALUOP_W'(w_alu_ex);
      S_MEM: begin
        // strobes stay asserted for the whole stall
        bus.alu_op = ALUOP_W'(w_alu_ex);
        bus.dm_re  = (w_op == OP_LOD);
        bus.dm_we  = (w_op == OP_STR);
      end
      S_WB: begin
        bus.alu_op = ALUOP_W'(w_alu_ex);
        bus.rf_we  = (w_op == OP_ALU) || (w_op == OP_LOD) || (w_op == OP_SWP);
        bus.wb_sel = (w_op == OP_LOD);
      end
      S_WB2: begin
        bus.alu_op = ALUOP_W'(w_alu_ex);
        bus.rf_we  = 1'b1;
        bus.rb_sel = 1'b1;
      end
      S_HALT:  bus.halted = 1'b1;
      default: ;
    endcase
  end

`ifdef SISC_CTRL_PERF_EN
  logic [31:0] r_cyc_cnt;
  logic [31:0] r_instr_cnt;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_cyc_cnt   <= 32'd0;
      r_instr_cnt <= 32'd0;
    end else begin
      if (r_state != S_START0 && r_state != S_START1 && r_state != S_HALT)
        r_cyc_cnt <= r_cyc_cnt + 32'd1;
      if ((r_state == S_WB || r_state == S_WB2) && w_state_next == S_FETCH)
        r_instr_cnt <= r_instr_cnt + 32'd1;
    end
  end

  assign bus.cyc_cnt   = r_cyc_cnt;
  assign bus.instr_cnt = r_instr_cnt;
`endif

endmodule

// File: tb/tb_sisc_ctrl_seq.sv
// Self-checking bench for sisc_ctrl_seq: vector table, hand sequences, random instructions.
`timescale 1ns/1ps
module tb_sisc_ctrl_seq;
  import sisc_pkg::*;

  logic clk = 1'b0;
  logic rst_f = 1'b0;
  always #5 clk = ~clk;

  sisc_ctrl_seq_if bus_if();

  sisc_ctrl_seq dut (
    .clk   (clk),
    .rst_f (rst_f),
    .bus   (bus_if)
  );

  typedef struct packed {
    logic       ir_load, pc_write, pc_sel, br_sel, pc_rst, rf_we, wb_sel, rb_sel;
    logic [1:0] alu_op;
    logic       dm_re, dm_we, halted;
    logic [3:0] st;
  } out_t;

  typedef struct {
    logic [3:0] op, mm, stat;
    int         k;
    logic       exp_pcw, exp_brsel;
    int         exp_lat;
  } vec_t;

  vec_t tbl[$];
  out_t exp_q[$];
  logic mr_q[$];
  out_t obs_dec;
  int   obs_lat;
  int   tests = 0;
  int   fails = 0;

  function automatic out_t mk(state_e s);
    out_t o = '0;
    o.alu_op = 2'b10;
    o.st     = s;
    return o;
  endfunction

  function automatic out_t reset_vec();
    out_t o = mk(S_START1);
    o.pc_rst = 1'b1;
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.ir_load  = bus_if.ir_load;   o.pc_write = bus_if.pc_write;
    o.pc_sel   = bus_if.pc_sel;    o.br_sel   = bus_if.br_sel;
    o.pc_rst   = bus_if.pc_rst;    o.rf_we    = bus_if.rf_we;
    o.wb_sel   = bus_if.wb_sel;    o.rb_sel   = bus_if.rb_sel;
    o.alu_op   = bus_if.alu_op;    o.dm_re    = bus_if.dm_re;
    o.dm_we    = bus_if.dm_we;     o.halted   = bus_if.halted;
    o.st       = bus_if.state_dbg;
    return o;
  endfunction

  task automatic check(input string nm, input out_t act, input out_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic push(input out_t o, input logic m);
    exp_q.push_back(o);
    mr_q.push_back(m);
  endtask

  // Reference: the per-cycle strobe list of one instruction, from FETCH to just before the next FETCH
  task automatic plan(input logic [3:0] op, input logic [3:0] mm, input logic [3:0] stat, input int k);
    out_t       o;
    bit         mem_op = (op == 4'd1) || (op == 4'd2);
    bit         brn    = (op >= 4'd4) && (op <= 4'd7);
    bit         neg    = (op == 4'd6) || (op == 4'd7);
    bit         taken  = brn && (((stat & mm) != 4'd0) != neg);
    logic [1:0] aop    = (op == 4'd8) ? ((mm == 4'd8) ? 2'b01 : 2'b00) : 2'b10;
    exp_q.delete();
    mr_q.delete();
    o = mk(S_FETCH); o.ir_load = 1'b1; o.pc_write = 1'b1;
    push(o, 1'($urandom_range(0, 1)));
    o = mk(S_DECODE);
    if (taken) begin
      o.pc_write = 1'b1; o.pc_sel = 1'b1; o.br_sel = (op == 4'd4) || (op == 4'd6);
    end
    push(o, 1'($urandom_range(0, 1)));
    if (op == 4'd15) begin
      for (int i = 0; i < 20; i++) begin
        o = mk(S_HALT); o.halted = 1'b1;
        push(o, 1'($urandom_range(0, 1)));
      end
      return;
    end
    o = mk(S_EXECUTE); o.alu_op = aop;
    push(o, 1'($urandom_range(0, 1)));
    for (int i = 0; i <= (mem_op ? k : 0); i++) begin
      o = mk(S_MEM); o.alu_op = aop;
      o.dm_re = (op == 4'd1); o.dm_we = (op == 4'd2);
      push(o, mem_op ? (i == k) : 1'($urandom_range(0, 1)));
    end
    o = mk(S_WB); o.alu_op = aop;
    o.rf_we  = (op == 4'd8) || (op == 4'd1) || (op == 4'd3);
    o.wb_sel = (op == 4'd1);
    push(o, 1'($urandom_range(0, 1)));
    if (op == 4'd3) begin
      o = mk(S_WB2); o.alu_op = aop; o.rf_we = 1'b1; o.rb_sel = 1'b1;
      push(o, 1'($urandom_range(0, 1)));
    end
  endtask

  // Entered #1 after the edge that starts FETCH; leaves #1 after the edge that starts the next FETCH
  task automatic run(input logic [3:0] op, input logic [3:0] mm, input logic [3:0] stat,
                     input int k, input bit halt_case);
    out_t act;
    int   i = 0;
    plan(op, mm, stat, k);
    bus_if.opcode = op;
    bus_if.mm     = mm;
    bus_if.stat   = stat;
    forever begin
      bus_if.mem_ready = (i < mr_q.size()) ? mr_q[i] : 1'b1;
      @(negedge clk);
      act = sample();
      if (i < exp_q.size())
        check($sformatf("op%0d_cyc%0d", op, i), act, exp_q[i]);
      else
        check($sformatf("op%0d_extra%0d", op, i), act, mk(S_FETCH));
      if (i == 1) obs_dec = act;
      @(posedge clk); #1;
      i++;
      if (halt_case ? (i == exp_q.size()) : (bus_if.ir_load === 1'b1)) break;
      if (i >= 64) begin
        tests++; fails++;
        $display("FAIL op%0d_timeout: got no FETCH within %0d cycles", op, i);
        break;
      end
    end
    obs_lat = i;
  endtask

  task automatic do_reset();
    rst_f = 1'b0;
    bus_if.mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", sample(), reset_vec());
    rst_f = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic add(input logic [3:0] op, input logic [3:0] mm, input logic [3:0] stat, input int k,
                     input logic pcw, input logic brs, input int lat);
    vec_t v;
    v.op = op; v.mm = mm; v.stat = stat; v.k = k;
    v.exp_pcw = pcw; v.exp_brsel = brs; v.exp_lat = lat;
    tbl.push_back(v);
  endtask

  initial begin
    logic [3:0] op, mm, stat;
    out_t       o;
    bus_if.opcode = 4'd0; bus_if.mm = 4'd0; bus_if.stat = 4'd0; bus_if.mem_ready = 1'b0;

    //   op     mm       stat     k  pcw   brsel lat
    add(4'd4, 4'b0010, 4'b0010, 0, 1'b1, 1'b1, 5);
    add(4'd4, 4'b0010, 4'b0100, 0, 1'b0, 1'b0, 5);
    add(4'd7, 4'b0001, 4'b0000, 0, 1'b1, 1'b0, 5);
    add(4'd7, 4'b0001, 4'b0001, 0, 1'b0, 1'b0, 5);
    add(4'd4, 4'b0000, 4'b1111, 0, 1'b0, 1'b0, 5);
    add(4'd6, 4'b0000, 4'b1111, 0, 1'b1, 1'b1, 5);
    add(4'd5, 4'b1100, 4'b0100, 0, 1'b1, 1'b0, 5);
    add(4'd6, 4'b0011, 4'b0001, 0, 1'b0, 1'b0, 5);
    add(4'd1, 4'b0000, 4'b0000, 3, 1'b0, 1'b0, 8);
    add(4'd2, 4'b0000, 4'b0000, 2, 1'b0, 1'b0, 7);
    add(4'd3, 4'b0000, 4'b0000, 0, 1'b0, 1'b0, 6);
    add(4'd8, 4'b1000, 4'b0000, 0, 1'b0, 1'b0, 5);
    add(4'd8, 4'b0011, 4'b0000, 0, 1'b0, 1'b0, 5);
    add(4'd0, 4'b0000, 4'b0000, 0, 1'b0, 1'b0, 5);
    add(4'd11, 4'b1111, 4'b1111, 0, 1'b0, 1'b0, 5);
    add(4'd1, 4'b0000, 4'b0000, 0, 1'b0, 1'b0, 5);

    do_reset();

    foreach (tbl[n]) begin
      run(tbl[n].op, tbl[n].mm, tbl[n].stat, tbl[n].k, 1'b0);
      check_int($sformatf("vec%0d_latency", n), obs_lat, tbl[n].exp_lat);
      check_int($sformatf("vec%0d_dec_pc_write", n), int'(obs_dec.pc_write), int'(tbl[n].exp_pcw));
      check_int($sformatf("vec%0d_dec_br_sel", n), int'(obs_dec.br_sel), int'(tbl[n].exp_brsel));
    end

    // HLT: parks in HALT for good, whatever mem_ready does
    run(4'd15, 4'd0, 4'd0, 0, 1'b1);
    do_reset();

    // Reset pulse in the middle of a stalled STR must drop dm_we at once
    bus_if.opcode = 4'd2; bus_if.mem_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    o = mk(S_MEM); o.dm_we = 1'b1;
    check("str_mem_stall", sample(), o);
    #2 rst_f = 1'b0;
    #1 check("str_abort_async", sample(), reset_vec());
    @(posedge clk);
    @(negedge clk) rst_f = 1'b1;
    @(posedge clk); #1;

    for (int n = 0; n < 150; n++) begin
      op   = 4'($urandom_range(0, 15));
      mm   = ($urandom_range(0, 3) == 0) ? 4'd8 : 4'($urandom);
      stat = 4'($urandom);
      if (op == 4'd15) begin
        run(op, mm, stat, 0, 1'b1);
        do_reset();
      end else begin
        run(op, mm, stat, $urandom_range(0, 4), 1'b0);
        check_int($sformatf("rand%0d_op%0d_latency", n, op), obs_lat, exp_q.size());
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
